spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Single-clock SPI master; the upstream stage that drives SPI_SLAVE's SS/SCK/MOSI and captures its MISO.
- Converts a parallel START/TX_DATA request into one full-duplex WIDTH-bit transfer in any of the four SPI modes.
- Returns the received word on RX_DATA with a one-cycle DONE pulse.
- Replaces testbench-generated SCK/SS with a synthesizable, system-clock-derived controller.

Parameters:
- WIDTH, 8, bits per transfer, MSB first.
- CLK_DIV, 4, CLK cycles per SCK half-period; legal range >= 1.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  reset, synchronous, active-high.
- START  input  1  transfer request; sampled only in IDLE.
- TX_DATA  input  WIDTH  word to send; latched with START.
- MODE  input  2  {CPOL,CPHA}; latched with START.
- RX_DATA  output  WIDTH  last received word; valid from DONE until the next DONE.
- BUSY  output  1  high from the cycle after START acceptance through the cycle before DONE.
- DONE  output  1  one-cycle pulse at transfer end.
- SS  output  1  slave select, active-low.
- SCK  output  1  SPI clock.
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in.

Behaviour:
- Reset values (registered, next CLK edge after RST=1, including mid-transfer): SS=1, SCK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, latched mode=00, state IDLE, counters 0.
- A transfer aborted by RST produces no DONE and leaves RX_DATA=0.
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE:
  - SS=1, SCK=CPOL of latched mode.
  - START=1 latches TX_DATA into the shift register and MODE into the mode register, then enters SETUP.
  - START in any other state is ignored; there is no queueing.
- SETUP (CLK_DIV cycles):
  - SS=0, BUSY=1, SCK idle level.
  - CPHA=0: MOSI = TX MSB from the first SETUP cycle.
  - CPHA=1: MOSI holds its previous value.
- XFER (2*WIDTH half-periods of CLK_DIV cycles each):
  - SCK toggles at every half-period boundary.
  - Edge k=1..2*WIDTH: odd k is the leading edge, even k is the trailing edge.
  - CPHA=0: leading edges sample MISO into the RX shift (LSB-in). Trailing edges k<2*WIDTH shift the next TX bit onto MOSI.
  - CPHA=1: leading edges shift the next TX bit onto MOSI (first leading edge = MSB). Trailing edges sample MISO.
  - Sampling happens on the same CLK edge that toggles SCK, so it captures the MISO value present before that SCK edge.
- HOLD (CLK_DIV cycles):
  - SS=0, SCK back at CPOL after edge 2*WIDTH, MOSI holds.
- Exit from HOLD (one cycle):
  - SS=1, BUSY=0, DONE=1, RX_DATA <= RX shift register, state IDLE.
  - A START on the following cycle is accepted, giving a guaranteed minimum SS-high time of 1 CLK.
- Latency: START accepted at edge 0; DONE high in cycle 1+CLK_DIV*(2*WIDTH+2). With defaults that is cycle 73.
- MODE/TX_DATA changes during BUSY have no effect.
- MISO is treated as synchronous to CLK; no synchronizer is included.
- Half-period counter: counts 0..CLK_DIV-1 and wraps. Edge counter: ceil(log2(2*WIDTH+1)) bits, no overflow.

Decomposition:
- Package spi_pkg:
  - state encoding (IDLE/SETUP/XFER/HOLD);
  - MODE bit indices: CPOL=1, CPHA=0;
  - mode constants SPI_MODE0..3 = 2'b00..2'b11.
- Sub-module spi_tick_div: CLK_DIV half-period tick generator with synchronous clear. It pulses a tick on the last cycle of each half-period, and the FSM consumes the ticks.

Test Plan:
- Mode 0, MOSI looped to MISO, TX_DATA=0xBA, START one cycle -> SCK idles 0 with 16 edges; SS low for cycles 1..72; DONE at cycle 73; RX_DATA=0xBA; MOSI sequence 1,0,1,1,1,0,1,0.
- Mode 0 against SPI_SLAVE loaded with DATA=0xEF, TX_DATA=0xBA -> RX_DATA=0xEF; slave receives 0xBA.
- Mode 3, loopback, TX_DATA=0x5A -> SCK idles 1 before and after; MOSI changes on falling SCK, sampled on rising; RX_DATA=0x5A.
- Mode 1, loopback, TX_DATA=0x81 -> first MOSI change on first (rising) edge; RX_DATA=0x81. Second START pulsed at cycle 20 is ignored, giving exactly one DONE.
- RST=1 at cycle 30 of a mode-2 transfer -> next cycle SS=1, SCK=0, BUSY=0, RX_DATA=0; no DONE. New START with TX=0x3C then completes normally.
- CLK_DIV=1 build, loopback mode 0, back-to-back START on the cycle after DONE -> two transfers, each DONE 19 cycles after START; SS high exactly 1 cycle between them; RX 0xA5 then 0x3C.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI master controller: FSM encoding and mode-bit layout.
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Bit positions inside the 2-bit {CPOL,CPHA} mode word
    localparam int CPOL = 1;
    localparam int CPHA = 0;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_tick_div.sv
// Half-period tick generator: pulses tick on the last of every CLK_DIV cycles.
module spi_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one full-duplex WIDTH-bit MSB-first transfer per accepted start,
// any of the four modes, SCK derived from clk by CLK_DIV cycles per half-period.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             ss,
    output logic             sck,
    output logic             mosi,
    input  logic             miso
);

    localparam int            EW        = $clog2(2 * WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [EW-1:0]    edge_cnt;
    logic             tick;
    logic             leading;
    logic             sample;

    spi_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_IDLE),
        .tick (tick)
    );

    // edge_cnt holds k-1 for the edge about to happen, so even means leading
    assign leading = ~edge_cnt[0];
    assign sample  = (leading != mode_q[CPHA]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= SPI_MODE0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            edge_cnt <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ss       <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            // NOTE: non-blocking default; the HOLD branch below overrides it for one cycle
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ss   <= 1'b1;
                    busy <= 1'b0;
                    sck  <= mode_q[CPOL];
                    if (start) begin
                        mode_q   <= mode;
                        sck      <= mode[CPOL];
                        ss       <= 1'b0;
                        busy     <= 1'b1;
                        edge_cnt <= '0;
                        state    <= ST_SETUP;
                        if (!mode[CPHA]) begin
                            mosi  <= tx_data[WIDTH-1];
                            tx_sh <= {tx_data[WIDTH-2:0], 1'b0};
                        end else begin
                            tx_sh <= tx_data;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tick) state <= ST_XFER;
                end
                ST_XFER: begin
                    if (tick) begin
                        sck      <= ~sck;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample) begin
                            rx_sh <= {rx_sh[WIDTH-2:0], miso};
                        end else if (edge_cnt != LAST_EDGE) begin
                            mosi  <= tx_sh[WIDTH-1];
                            tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
                        end
                        if (edge_cnt == LAST_EDGE) state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state   <= ST_IDLE;
                        ss      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sh;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: default build (CLK_DIV=4) plus a CLK_DIV=1 build.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    typedef struct {
        logic [7:0] rx;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    // default-divider DUT
    logic       start = 1'b0;
    logic [7:0] tx_data = '0;
    logic [1:0] mode = '0;
    logic [7:0] rx_data;
    logic       busy, done, ss, sck, mosi, miso;
    logic       use_slave = 1'b0;

    // CLK_DIV=1 DUT, MOSI looped back
    logic       start1 = 1'b0;
    logic [7:0] tx1 = '0;
    logic [1:0] mode1 = '0;
    logic [7:0] rx1;
    logic       busy1, done1, ss1, sck1, mosi1;

    // mode-0 slave model
    logic [7:0] sl_sh = '0;
    logic [7:0] sl_rx = '0;
    logic       sl_miso = 1'b0;
    logic       sl_sck_prev = 1'b0;

    assign miso = use_slave ? sl_miso : mosi;

    spi_master_ctrl #(.WIDTH(8), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .mode(mode),
        .rx_data(rx_data), .busy(busy), .done(done), .ss(ss), .sck(sck),
        .mosi(mosi), .miso(miso)
    );

    spi_master_ctrl #(.WIDTH(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .mode(mode1),
        .rx_data(rx1), .busy(busy1), .done(done1), .ss(ss1), .sck(sck1),
        .mosi(mosi1), .miso(mosi1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (ss) begin
            sl_sh   <= 8'hEF;
            sl_miso <= 1'b1;
        end else if (sck && !sl_sck_prev) begin
            sl_rx <= {sl_rx[6:0], mosi};
        end else if (!sck && sl_sck_prev) begin
            sl_miso <= sl_sh[6];
            sl_sh   <= {sl_sh[6:0], 1'b0};
        end
        sl_sck_prev <= sck;
    end

    // Monitors: every DONE pops the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q0.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("rx_data", rx_data, e.rx);
                check("done_cycle", cyc, e.cyc);
            end
        end
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                check("spurious_done1", done1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("rx_data1", rx1, e.rx);
                check("done_cycle1", cyc, e.cyc);
            end
        end
    end

    task automatic run_xfer(input logic [7:0] tx, input logic [1:0] md,
                            input logic [7:0] exp_rx, input int dup_at);
        logic       cpol, cpha, prev_sck, prev_mosi;
        logic [7:0] word;
        int         ss_low, edges, bad, rel;
        cpol = md[CPOL];
        cpha = md[CPHA];
        @(negedge clk);
        tx_data = tx;
        mode    = md;
        start   = 1'b1;
        q0.push_back('{exp_rx, cyc + 1 + 4 * 18});
        @(negedge clk);
        start   = 1'b0;
        tx_data = ~tx;
        mode    = ~md;
        check("sck_setup_idle", sck, cpol);
        prev_sck  = sck;
        prev_mosi = mosi;
        ss_low = 0; edges = 0; bad = 0; rel = 1; word = '0;
        while (!done && rel < 300) begin
            if (!ss) ss_low++;
            if (sck != prev_sck) begin
                edges++;
                if ((sck ^ cpol ^ cpha) == 1'b1) word = {word[6:0], mosi};
            end
            if (mosi != prev_mosi && !(sck != prev_sck && (sck ^ cpol ^ cpha) == 1'b0)) bad++;
            prev_sck  = sck;
            prev_mosi = mosi;
            start   = (rel == dup_at);
            tx_data = 8'hFF;
            @(negedge clk);
            rel++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("ss_high_at_done", ss, 1);
        check("busy_low_at_done", busy, 0);
        check("sck_hold_idle", sck, cpol);
        check("ss_low_cycles", ss_low, 72);
        check("sck_edges", edges, 16);
        check("mosi_sequence", word, tx);
        check("mosi_timing", bad, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);
        check("rst_ss1", ss1, 1);
        check("rst_rx1", rx1, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_xfer(8'hBA, SPI_MODE0, 8'hBA, 0);

        use_slave = 1'b1;
        run_xfer(8'hBA, SPI_MODE0, 8'hEF, 0);
        check("slave_rx", sl_rx, 8'hBA);
        use_slave = 1'b0;

        run_xfer(8'h5A, SPI_MODE3, 8'h5A, 0);
        repeat (2) @(negedge clk);
        check("mode3_idle_sck", sck, 1);

        run_xfer(8'h81, SPI_MODE1, 8'h81, 19);
        repeat (10) @(negedge clk);
        check("no_queued_start", busy, 0);

        // abort a mode-2 transfer with reset at cycle 30
        tx_data = 8'h77;
        mode    = SPI_MODE2;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ss", ss, 1);
        check("abort_sck", sck, 0);
        check("abort_busy", busy, 0);
        check("abort_rx", rx_data, 0);
        repeat (90) @(negedge clk);
        check("abort_rx_after", rx_data, 0);
        run_xfer(8'h3C, SPI_MODE2, 8'h3C, 0);

        // CLK_DIV=1 back-to-back transfers
        tx1    = 8'hA5;
        mode1  = SPI_MODE0;
        start1 = 1'b1;
        q1.push_back('{8'hA5, cyc + 19});
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done1_first", done1, 1);
        check("ss1_gap_high", ss1, 1);
        tx1    = 8'h3C;
        start1 = 1'b1;
        q1.push_back('{8'h3C, cyc + 19});
        @(negedge clk);
        start1 = 1'b0;
        check("ss1_low_again", ss1, 0);
        n = 0;
        while (!done1 && n < 100) begin
            if (ss1) n += 1000;
            @(negedge clk);
            n++;
        end
        check("done1_second", done1, 1);
        check("ss1_stays_low", n < 1000, 1);

        repeat (5) @(negedge clk);
        check("pending_done0", q0.size(), 0);
        check("pending_done1", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
